// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : Single-outstanding data memory responder with fixed response
//           latency, byte-enabled stores and range/enable error detection.
// Revision: 1.0
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);
    localparam logic       c_lat1   = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_err;

    logic [31:0] r_mem [0:(1 << ADDR_W) - 1];

    logic              w_in_err;
    logic              w_accept;
    logic              w_enter_resp;
    logic              w_we;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_wdata;
    logic [3:0]        w_be;
    logic              w_err;
    logic              w_commit;
    logic [31:0]       w_resp_rdata;
    logic              w_unused;

    assign w_unused = ^req_addr[1:0];

    assign w_in_err = ((req_addr >> (ADDR_W + 2)) != 32'd0) || (req_we && (req_be == 4'b0000));
    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_enter_resp = (w_accept && c_lat1) || ((r_state == WAIT) && (r_cnt == 4'd1));

    // With a one-cycle latency the RESP entry edge is the accept edge itself,
    // so the live request fields stand in for the not-yet-latched copies.
    assign w_we    = (r_state == IDLE) ? req_we                  : r_we;
    assign w_idx   = (r_state == IDLE) ? req_addr[ADDR_W+1:2]    : r_idx;
    assign w_wdata = (r_state == IDLE) ? req_wdata               : r_wdata;
    assign w_be    = (r_state == IDLE) ? req_be                  : r_be;
    assign w_err   = (r_state == IDLE) ? w_in_err                : r_err;

    assign w_commit     = w_enter_resp && w_we && !w_err && reset;
    assign w_resp_rdata = (!w_we && !w_err) ? r_mem[w_idx] : 32'd0;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_err      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we      <= req_we;
                        r_idx     <= req_addr[ADDR_W+1:2];
                        r_wdata   <= req_wdata;
                        r_be      <= req_be;
                        r_err     <= w_in_err;
                        req_ready <= 1'b0;
                        if (c_lat1) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= w_err;
                            resp_rdata <= w_resp_rdata;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_lat_m1;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state    <= RESP;
                        r_cnt      <= 4'd0;
                        resp_valid <= 1'b1;
                        resp_err   <= w_err;
                        resp_rdata <= w_resp_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state    <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_cnt      <= 4'd0;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Brief   : Directed self-checking bench for data_mem_responder at
//           latencies 2, 1 and 15.
// Revision: 1.0
// ============================================================================
module tb_data_mem_responder;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        req_valid_m, req_ready_m, resp_valid_m, resp_ready_m, resp_err_m;
    logic [31:0] resp_rdata_m;
    logic        req_valid_a, req_ready_a, resp_valid_a, resp_ready_a, resp_err_a;
    logic [31:0] resp_rdata_a;
    logic        req_valid_b, req_ready_b, resp_valid_b, resp_ready_b, resp_err_b;
    logic [31:0] resp_rdata_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut_m (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_m), .req_ready(req_ready_m),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid_m), .resp_ready(resp_ready_m),
        .resp_rdata(resp_rdata_m), .resp_err(resp_err_m)
    );

    data_mem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
    );

    data_mem_responder #(.ADDR_W(10), .LATENCY(15)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full request/response on the LATENCY=2 instance.
    task automatic txn_m(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        chk({tag, "_rdy"}, 32'(req_ready_m), 32'd1);
        req_valid_m = 1'b1;
        tick;
        req_valid_m = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        n = 1;
        while (resp_valid_m !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd2);
        chk({tag, "_rdata"}, resp_rdata_m, exp_rdata);
        chk({tag, "_err"}, 32'(resp_err_m), 32'(exp_err));
        resp_ready_m = 1'b1;
        tick;
        resp_ready_m = 1'b0;
        chk({tag, "_vld0"}, 32'(resp_valid_m), 32'd0);
        chk({tag, "_rdy1"}, 32'(req_ready_m), 32'd1);
    endtask

    initial begin
        int n;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        req_valid_m = 1'b0; resp_ready_m = 1'b0;
        req_valid_a = 1'b0; resp_ready_a = 1'b0;
        req_valid_b = 1'b0; resp_ready_b = 1'b0;

        #1 reset = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready_m), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid_m), 32'd0);
        chk("rst_resp_rdata", resp_rdata_m, 32'd0);
        chk("rst_resp_err", 32'(resp_err_m), 32'd0);
        tick;
        tick;
        reset = 1'b1;

        // Full-word store and readback, then single-lane merge
        txn_m("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
        txn_m("ld_full", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);
        txn_m("st_lane0", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'd0, 1'b0);
        txn_m("ld_lane0", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0);

        // Error paths: out-of-range load, store with no byte enables
        txn_m("st_w4", 1'b1, 32'h04, 32'h55AA55AA, 4'hF, 32'd0, 1'b0);
        txn_m("ld_oor", 1'b0, 32'h00001000, 32'd0, 4'h0, 32'd0, 1'b1);
        txn_m("st_be0", 1'b1, 32'h04, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b1);
        txn_m("ld_w4", 1'b0, 32'h04, 32'd0, 4'h0, 32'h55AA55AA, 1'b0);

        // Backpressure: hold resp_ready low for 5 cycles in RESP
        req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
        req_valid_m = 1'b1;
        tick;
        req_valid_m = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            req_addr = 32'h04;
            chk("bp_valid", 32'(resp_valid_m), 32'd1);
            chk("bp_rdata", resp_rdata_m, 32'hDEADBEAA);
            chk("bp_err", 32'(resp_err_m), 32'd0);
            chk("bp_req_ready", 32'(req_ready_m), 32'd0);
            tick;
        end
        resp_ready_m = 1'b1;
        tick;
        resp_ready_m = 1'b0;
        chk("bp_done_valid", 32'(resp_valid_m), 32'd0);
        chk("bp_done_ready", 32'(req_ready_m), 32'd1);

        // Reset during WAIT discards a pending store
        txn_m("st_w20_zero", 1'b1, 32'h20, 32'h0, 4'hF, 32'd0, 1'b0);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
        req_valid_m = 1'b1;
        tick;
        req_valid_m = 1'b0;
        chk("wait_req_ready", 32'(req_ready_m), 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_req_ready", 32'(req_ready_m), 32'd1);
        chk("arst_resp_valid", 32'(resp_valid_m), 32'd0);
        chk("arst_resp_rdata", resp_rdata_m, 32'd0);
        chk("arst_resp_err", 32'(resp_err_m), 32'd0);
        #1 reset = 1'b1;
        tick;
        chk("arst_no_resp", 32'(resp_valid_m), 32'd0);
        txn_m("ld_w20", 1'b0, 32'h20, 32'd0, 4'h0, 32'h00000000, 1'b0);

        // LATENCY = 1: response on the edge after accept
        req_we = 1'b1; req_addr = 32'h08; req_wdata = 32'h11223344; req_be = 4'hF;
        req_valid_a = 1'b1;
        tick;
        req_valid_a = 1'b0;
        chk("l1_st_valid", 32'(resp_valid_a), 32'd1);
        chk("l1_st_err", 32'(resp_err_a), 32'd0);
        resp_ready_a = 1'b1;
        tick;
        resp_ready_a = 1'b0;
        chk("l1_st_done", 32'(req_ready_a), 32'd1);
        req_we = 1'b0; req_wdata = 32'd0;
        req_valid_a = 1'b1;
        tick;
        req_valid_a = 1'b0;
        chk("l1_ld_valid", 32'(resp_valid_a), 32'd1);
        chk("l1_ld_rdata", resp_rdata_a, 32'h11223344);
        resp_ready_a = 1'b1;
        tick;
        resp_ready_a = 1'b0;

        // LATENCY = 15 with req_valid held and inputs changed during WAIT
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        req_valid_b = 1'b1;
        tick;
        req_we = 1'b0; req_addr = 32'h44; req_wdata = 32'h0; req_be = 4'h0;
        n = 1;
        while (resp_valid_b !== 1'b1 && n < 40) begin
            if (req_ready_b !== 1'b0) begin
                chk("l15_wait_ready", 32'(req_ready_b), 32'd0);
            end
            tick;
            n++;
        end
        req_valid_b = 1'b0;
        chk("l15_st_lat", 32'(n), 32'd15);
        chk("l15_st_rdata", resp_rdata_b, 32'd0);
        chk("l15_st_err", 32'(resp_err_b), 32'd0);
        resp_ready_b = 1'b1;
        tick;
        resp_ready_b = 1'b0;
        chk("l15_no_second", 32'(resp_valid_b), 32'd0);
        tick;
        chk("l15_idle_ready", 32'(req_ready_b), 32'd1);
        req_we = 1'b0; req_addr = 32'h40;
        req_valid_b = 1'b1;
        tick;
        req_valid_b = 1'b0;
        n = 1;
        while (resp_valid_b !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk("l15_ld_lat", 32'(n), 32'd15);
        chk("l15_ld_rdata", resp_rdata_b, 32'hCAFEF00D);
        resp_ready_b = 1'b1;
        tick;
        resp_ready_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning word-address width (depth 2^ADDR_W 32-bit words).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning cycles from request accept edge to resp_valid high; legal range 1..15.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 The block SHALL have port req_valid  input  1  CPU request present.
REQ-006 The block SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 The block SHALL have port req_wdata  input  32  store data.
REQ-010 The block SHALL have port req_be  input  4  store byte enables; bit i enables byte lane [8i+7:8i].
REQ-011 The block SHALL have port resp_valid  output  1  response present.
REQ-012 The block SHALL have port resp_ready  input  1  CPU accepts the response.
REQ-013 The block SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 The block SHALL have port resp_err  output  1  request was rejected.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-016 Accept SHALL occur on a rising edge with req_valid & req_ready; we, addr, wdata, be are latched at that edge; later input changes SHALL have no effect.
REQ-017 On accept, with LATENCY = 1 the FSM SHALL go IDLE->RESP; otherwise IDLE->WAIT with counter loaded to LATENCY-1.
REQ-018 In WAIT the counter SHALL decrement each cycle; when it reaches 1, the next edge SHALL go WAIT->RESP, giving resp_valid high exactly LATENCY cycles after the accept edge.
REQ-019 A request SHALL be flagged as an error when latched addr[31:ADDR_W+2] != 0, or when it is a store with be == 4'b0000.
REQ-020 A non-error store SHALL commit the enabled byte lanes to memory on the edge entering RESP; disabled lanes SHALL be unchanged; error stores SHALL write nothing.
REQ-021 A non-error load SHALL present the full word at addr[ADDR_W+1:2] on resp_rdata throughout RESP, including all stores committed before entry into RESP.
REQ-022 resp_rdata, resp_err SHALL stay stable while resp_valid = 1 and resp_ready = 0.
REQ-023 On an edge with resp_valid & resp_ready the FSM SHALL go RESP->IDLE; req_ready SHALL rise the following cycle (no same-cycle accept; max throughput one request per LATENCY+1 cycles).
REQ-024 req_valid during WAIT or RESP SHALL be ignored and not queued.
REQ-025 resp_ready while not in RESP SHALL be ignored.

Reset
REQ-026 reset = 0 SHALL immediately (asynchronously) force state IDLE, counter 0, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0.
REQ-027 Memory contents SHALL NOT be reset; contents are undefined until written.
REQ-028 Reset asserted in WAIT SHALL discard the pending request; an uncommitted store SHALL NOT modify memory.
REQ-029 Reset deassertion SHALL be sampled synchronously; the first accept is permitted on the first rising edge with reset = 1.

Verification
REQ-030 Store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 with LATENCY = 2 -> resp_valid 2 cycles after each accept, load resp_rdata = 0xDEADBEEF, resp_err 0.
REQ-031 After REQ-030, store addr 0x10, wdata 0x000000AA, be 4'b0001, then load 0x10 -> resp_rdata = 0xDEADBEAA.
REQ-032 Load addr 0x00001000 with ADDR_W = 10 -> resp_err 1, resp_rdata 0; store be 4'b0000 to 0x04 -> resp_err 1, word 0x04 unchanged.
REQ-033 Hold resp_ready = 0 for 5 cycles in RESP -> resp_valid, resp_rdata, resp_err constant and req_ready 0; raise resp_ready -> IDLE next edge, req_ready 1 the cycle after the handshake.
REQ-034 Store 0x12345678 to 0x20 (previously 0x0) and pulse reset low during WAIT -> outputs at reset values immediately; subsequent load 0x20 returns 0x00000000.
REQ-035 Sweep LATENCY = 1 and 15 -> resp_valid exactly 1 and 15 cycles after the accept edge; req_valid held high in WAIT causes no second accept.
